// File: rtl/fir_inverse.sv
// ---------------------------------------------------------------------------
// fir_inverse
//   Streaming deconvolver for the 4-tap FIR with coefficients b[k] = k+1.
//   Recovers x[n] = y[n] - sum_{k=1..N-1} (k+1)*x[n-k] using one MAC step
//   per cycle. Each recovered sample is clipped to 16 bits, and the clipped
//   value is what enters the history.
//
//   Optional feature (macro FIR_INV_SAT_FLAG_EN): adds a per-sample clip
//   flag and a sticky 16-bit count of clipped samples.
//
// Parameters:
//   N      number of taps (2..8)
//   ACC_W  signed accumulator width (>= 36)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   yn         signed 32-bit filtered sample in
//   in_valid   yn is valid
//   in_ready   block can accept yn (combinational, high only when idle)
//   xn         signed 16-bit recovered sample out (registered)
//   out_valid  xn is valid (registered)
//   out_ready  downstream accepts xn
//   sat_flag   [FIR_INV_SAT_FLAG_EN] xn was clipped; valid with out_valid
//   sat_count  [FIR_INV_SAT_FLAG_EN] saturating count of clipped samples
// ---------------------------------------------------------------------------
module fir_inverse #(
    parameter int N     = 4,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] yn,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [15:0] xn,
    output logic               out_valid,
    input  logic               out_ready
`ifdef FIR_INV_SAT_FLAG_EN
    ,
    output logic               sat_flag,
    output logic        [15:0] sat_count
`endif
);

    localparam int K_W = $clog2(N);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic        [K_W-1:0]   k_q;
    logic signed [15:0]      hist_q [N-1];
    logic signed [15:0]      xn_q;
    logic                    out_valid_q;

    // Datapath for the current MAC step.
    logic signed [15:0]      tap_val;
    logic signed [ACC_W-1:0] coef;
    logic signed [ACC_W-1:0] tap_ext;
    logic signed [ACC_W-1:0] acc_d;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [15:0]      sat_val_d;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        // Select hist[k-1] with an explicit compare so k=0 never indexes
        // outside the history array.
        tap_val = '0;
        for (int j = 0; j < N - 1; j++) begin
            if (k_q == K_W'(j + 1)) begin
                tap_val = hist_q[j];
            end
        end
        coef      = ACC_W'(k_q) + ACC_W'(1);
        tap_ext   = ACC_W'(tap_val);
        acc_d     = acc_q - coef * tap_ext;
        sat_hi    = acc_d > SAT_MAX;
        sat_lo    = acc_d < SAT_MIN;
        sat_val_d = sat_hi ? 16'sh7fff :
                    sat_lo ? 16'sh8000 : acc_d[15:0];
    end

    assign in_ready  = (state_q == IDLE);
    assign xn        = xn_q;
    assign out_valid = out_valid_q;

`ifdef FIR_INV_SAT_FLAG_EN
    logic        sat_flag_q;
    logic [15:0] sat_count_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            xn_q        <= '0;
            out_valid_q <= 1'b0;
            // NOTE: the history is a small register array, not a RAM, and
            // must be cleared so a reset really forgets previous samples.
            for (int j = 0; j < N - 1; j++) begin
                hist_q[j] <= '0;
            end
`ifdef FIR_INV_SAT_FLAG_EN
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q   <= ACC_W'(yn);
                        k_q     <= K_W'(1);
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + K_W'(1);
                    if (k_q == K_W'(N - 1)) begin
                        xn_q        <= sat_val_d;
                        out_valid_q <= 1'b1;
                        hist_q[0]   <= sat_val_d;
                        for (int j = 1; j < N - 1; j++) begin
                            hist_q[j] <= hist_q[j-1];
                        end
`ifdef FIR_INV_SAT_FLAG_EN
                        sat_flag_q <= sat_hi | sat_lo;
                        if ((sat_hi | sat_lo) && (sat_count_q != 16'hffff)) begin
                            sat_count_q <= sat_count_q + 16'd1;
                        end
`endif
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule
